gcd_inner: RTL and testbench

GCD_INNER -- requirements
Module: gcd_inner

---
 rtl/gcd_inner.sv | 47 ++++
 tb/tb_gcd_inner.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/gcd_inner.sv
// Subtractive GCD engine: loads an operand pair, then iterates one subtraction per clock until y reaches zero.
// Optional macro GCD_INNER_ZERO_GUARD_EN: a load with io_a=0 and io_b!=0 finishes at once instead of spinning forever.
module gcd_inner #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic             io_e,
  output logic [WIDTH-1:0] io_z,
  output logic             io_v
);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (io_e) begin
`ifdef GCD_INNER_ZERO_GUARD_EN
      // gcd(0,b) = b; store it finished rather than letting y-x=y repeat forever.
      if (io_a == '0 && io_b != '0) begin
        x <= io_b;
        y <= '0;
      end else begin
        x <= io_a;
        y <= io_b;
      end
`else
      x <= io_a;
      y <= io_b;
`endif
    end else if (y != '0) begin
      // Always subtract the smaller from the larger, so the difference never wraps.
      if (x > y) x <= x - y;
      else       y <= y - x;
    end
  end

  assign io_z = x;
  assign io_v = (y == '0);

endmodule

// File: tb/tb_gcd_inner.sv
// Directed self-checking bench for gcd_inner: reset, loads, reload abort, async reset, zero-operand cases.
// Expectations for io_a=0 loads follow GCD_INNER_ZERO_GUARD_EN when it is defined.
module tb_gcd_inner;

  localparam int WIDTH = 16;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] io_a;
  logic [WIDTH-1:0] io_b;
  logic             io_e;
  logic [WIDTH-1:0] io_z;
  logic             io_v;

  int total = 0;
  int bad   = 0;

  gcd_inner #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .io_a  (io_a),
    .io_b  (io_b),
    .io_e  (io_e),
    .io_z  (io_z),
    .io_v  (io_v)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present a pair for exactly one rising edge; returns at the following falling edge.
  task automatic load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clock);
    io_a = a;
    io_b = b;
    io_e = 1'b1;
    @(negedge clock);
    io_e = 1'b0;
  endtask

  // Counts edges until io_v rises; returns budget+1 if it never does.
  task automatic wait_valid(input int budget, output int cycles);
    cycles = budget + 1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clock);
      if (io_v) begin
        cycles = i;
        break;
      end
    end
  endtask

  int  cyc;
  bit  seen_v;

  initial begin
    io_a  = '0;
    io_b  = '0;
    io_e  = 1'b0;
    reset = 1'b0;
    #12;
    check("rst_async_v", 32'(io_v), 1);
    check("rst_async_z", 32'(io_z), 0);
    #10 reset = 1'b1;
    repeat (2) @(negedge clock);
    check("post_rst_v", 32'(io_v), 1);
    check("post_rst_z", 32'(io_z), 0);

    // (12,8): three subtraction steps.
    load(16'd12, 16'd8);
    check("12_8_load_v", 32'(io_v), 0);
    check("12_8_load_z", 32'(io_z), 12);
    wait_valid(20, cyc);
    check("12_8_latency", 32'(cyc), 3);
    check("12_8_z", 32'(io_z), 4);
    repeat (5) @(negedge clock);
    check("12_8_hold_v", 32'(io_v), 1);
    check("12_8_hold_z", 32'(io_z), 4);

    // b=0 finishes on the load itself.
    load(16'd7, 16'd0);
    check("7_0_v", 32'(io_v), 1);
    check("7_0_z", 32'(io_z), 7);

    load(16'd0, 16'd0);
    check("0_0_v", 32'(io_v), 1);
    check("0_0_z", 32'(io_z), 0);

    // Equal operands: one step.
    load(16'd9, 16'd9);
    wait_valid(5, cyc);
    check("9_9_latency", 32'(cyc), 1);
    check("9_9_z", 32'(io_z), 9);

    // Abandoned pair (48,18) replaced by (9,6) after two steps.
    load(16'd48, 16'd18);
    seen_v = io_v;
    repeat (2) begin
      @(negedge clock);
      seen_v |= io_v;
    end
    check("48_18_no_v", 32'(seen_v), 0);
    check("48_18_x2", 32'(io_z), 12);
    load(16'd9, 16'd6);
    wait_valid(20, cyc);
    check("9_6_latency", 32'(cyc), 3);
    check("9_6_z", 32'(io_z), 3);

    // Holding io_e high keeps reloading; no progress.
    @(negedge clock);
    io_a = 16'd12;
    io_b = 16'd8;
    io_e = 1'b1;
    repeat (4) @(negedge clock);
    check("hold_e_v", 32'(io_v), 0);
    check("hold_e_z", 32'(io_z), 12);
    io_e = 1'b0;
    wait_valid(20, cyc);
    check("hold_e_release_z", 32'(io_z), 4);

    // Full-width operands: 65535 = 255*257 -> 256 x-steps then one y-step.
    load(16'hFFFF, 16'd255);
    wait_valid(400, cyc);
    check("max_latency", 32'(cyc), 257);
    check("max_z", 32'(io_z), 255);

    // Zero first operand.
    load(16'd0, 16'd5);
`ifdef GCD_INNER_ZERO_GUARD_EN
    check("0_5_v", 32'(io_v), 1);
    check("0_5_z", 32'(io_z), 5);
`else
    seen_v = io_v;
    repeat (100) begin
      @(negedge clock);
      seen_v |= io_v;
    end
    check("0_5_never_v", 32'(seen_v), 0);
    check("0_5_z", 32'(io_z), 0);
`endif

    // Async reset mid-computation, between edges.
    load(16'd48, 16'd18);
    @(negedge clock);
    check("pre_rst_v", 32'(io_v), 0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_v", 32'(io_v), 1);
    check("mid_rst_z", 32'(io_z), 0);
    #4 reset = 1'b1;
    repeat (3) @(negedge clock);
    check("after_rst_v", 32'(io_v), 1);
    check("after_rst_z", 32'(io_z), 0);

    // Engine usable again after reset.
    load(16'd21, 16'd14);
    wait_valid(20, cyc);
    check("21_14_latency", 32'(cyc), 3);
    check("21_14_z", 32'(io_z), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
